mips_mc_ctrl: RTL and testbench

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_pkg.sv | 157 +++++++++++++++
 rtl/mips_alu_dec.sv | 32 +++
 rtl/mips_mc_ctrl.sv | 112 +++++++++++
 tb/tb_mips_mc_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS controller:
//   - opcode and funct field constants
//   - ALU control codes
//   - pc_src / reg_dst / wb_sel / alu_src_b mux encodings
//   - controller state enum and the registered control-word struct
//   - moore_ctrl(): control word that belongs to a given state
// -----------------------------------------------------------------------------
package mips_pkg;

   // Opcodes (instruction bits [31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type funct codes (instruction bits [5:0])
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU control codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // PC source select
   localparam logic [1:0] PC_SRC_PC4 = 2'd0;
   localparam logic [1:0] PC_SRC_BR  = 2'd1;
   localparam logic [1:0] PC_SRC_JMP = 2'd2;
   localparam logic [1:0] PC_SRC_RS  = 2'd3;

   // Register-file write address select
   localparam logic [1:0] REG_DST_RT = 2'd0;
   localparam logic [1:0] REG_DST_RD = 2'd1;
   localparam logic [1:0] REG_DST_RA = 2'd2;

   // Register-file write data select
   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   // ALU B operand select
   localparam logic [1:0] B_SEL_RT   = 2'd0;
   localparam logic [1:0] B_SEL_FOUR = 2'd1;
   localparam logic [1:0] B_SEL_IMM  = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_JAL,
      S_JR,
      S_HALT
   } state_t;

   // Registered (pure Moore) part of the control word
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic       halted;
   } ctrl_t;

   // Control word for state s. r_alu is the decoded R-type ALU op, used
   // only for EXEC_R; from_r selects rd vs rt as the WB_ALU destination.
   // FETCH's fetch-complete strobes depend on mem_ready and are added
   // combinationally in the top level, so they are not produced here.
   function automatic ctrl_t moore_ctrl(input state_t     s,
                                        input logic [2:0] r_alu,
                                        input logic       from_r);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_b = B_SEL_RT;
            c.alu_ctrl  = r_alu;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            c.alu_src_b = B_SEL_IMM;
            c.alu_ctrl  = ALU_ADD;
         end
         S_MEM_RD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
            c.mem_we  = 1'b1;
         end
         S_WB_ALU: begin
            c.reg_we  = 1'b1;
            c.wb_sel  = WB_SEL_ALU;
            c.reg_dst = from_r ? REG_DST_RD : REG_DST_RT;
         end
         S_WB_MEM: begin
            c.reg_we  = 1'b1;
            c.wb_sel  = WB_SEL_MEM;
            c.reg_dst = REG_DST_RT;
         end
         S_BRANCH: begin
            // pc_we is resolved from zero in the top level
            c.alu_src_b = B_SEL_RT;
            c.alu_ctrl  = ALU_SUB;
            c.pc_src    = PC_SRC_BR;
         end
         S_JAL: begin
            c.reg_we  = 1'b1;
            c.reg_dst = REG_DST_RA;
            c.wb_sel  = WB_SEL_PC4;
            c.pc_we   = 1'b1;
            c.pc_src  = PC_SRC_JMP;
         end
         S_JR: begin
            c.pc_we  = 1'b1;
            c.pc_src = PC_SRC_RS;
         end
         S_HALT: begin
            c.halted = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// -----------------------------------------------------------------------------
// mips_alu_dec
// Combinational R-type funct decoder.
// Ports:
//   funct    in  [5:0]  instruction bits [5:0]
//   alu_ctrl out [2:0]  ALU operation for this funct (ADD when unsupported)
//   r_legal  out        funct is one of the supported ALU R-type operations
// -----------------------------------------------------------------------------
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       r_legal
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      r_legal  = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         FN_SLL:  alu_ctrl = ALU_SLL;
         FN_SRL:  alu_ctrl = ALU_SRL;
         default: r_legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// mips_mc_ctrl
// Multi-cycle MIPS control FSM (Moore, registered control word).
// Parameter:
//   HALT_ON_ILLEGAL  1: unsupported instruction enters HALT; 0: refetch
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op, funct             instruction-register fields [31:26], [5:0]
//   zero                  registered ALU zero flag
//   mem_ready             shared memory finished current access
//   mem_req, mem_we, iord memory request, write, address select (PC/ALU-out)
//   ir_we, pc_we, pc_src  IR load, PC load and PC source
//   reg_we, reg_dst, wb_sel  register-file write enable/address/data select
//   alu_src_b, alu_ctrl   ALU B-operand select and operation
//   halted                controller parked in HALT
// -----------------------------------------------------------------------------
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned HALT_ON_ILLEGAL = 1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       reg_we,
   output logic [1:0] reg_dst,
   output logic [1:0] wb_sel,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       halted
);

   state_t     state;
   state_t     state_nxt;
   ctrl_t      ctrl_q;
   logic [2:0] r_alu;
   logic       r_legal;
   logic       fetch_go;
   logic       br_take;

   mips_alu_dec u_alu_dec (
      .funct    (funct),
      .alu_ctrl (r_alu),
      .r_legal  (r_legal)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            if (op == OP_RTYPE && funct == FN_JR)  state_nxt = S_JR;
            else if (op == OP_RTYPE && r_legal)    state_nxt = S_EXEC_R;
            else if (op == OP_JAL)                 state_nxt = S_JAL;
            else if (op == OP_BEQ || op == OP_BNE) state_nxt = S_BRANCH;
            else if (op == OP_ADDI)                state_nxt = S_EXEC_I;
            else if (op == OP_LW || op == OP_SW)   state_nxt = S_MEM_ADDR;
            else if (HALT_ON_ILLEGAL != 0)         state_nxt = S_HALT;
            else                                   state_nxt = S_FETCH;
         end
         S_EXEC_R,
         S_EXEC_I:   state_nxt = S_WB_ALU;
         S_MEM_ADDR: state_nxt = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_nxt = S_WB_MEM;
         S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_FETCH;
      endcase
   end

   // The control word is computed for the state being entered so that
   // every Moore output comes straight from a flop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_FETCH;
         ctrl_q <= moore_ctrl(S_FETCH, ALU_ADD, 1'b0);
      end else begin
         state  <= state_nxt;
         ctrl_q <= moore_ctrl(state_nxt, r_alu, state == S_EXEC_R);
      end
   end

   // Fetch completes in the cycle mem_ready is seen; an access being
   // aborted by reset must not load IR/PC, hence the rst_n qualifier.
   assign fetch_go = (state == S_FETCH) && mem_ready && rst_n;
   // BEQ takes on zero=1, BNE on zero=0.
   assign br_take  = (state == S_BRANCH) && (zero ^ (op == OP_BNE));

   assign mem_req   = ctrl_q.mem_req;
   assign mem_we    = ctrl_q.mem_we;
   assign iord      = ctrl_q.iord;
   assign ir_we     = fetch_go;
   assign pc_we     = rst_n && (ctrl_q.pc_we || fetch_go || br_take);
   assign pc_src    = ctrl_q.pc_src;
   assign reg_we    = rst_n && ctrl_q.reg_we;
   assign reg_dst   = ctrl_q.reg_dst;
   assign wb_sel    = ctrl_q.wb_sel;
   assign alu_src_b = fetch_go ? B_SEL_FOUR : ctrl_q.alu_src_b;
   assign alu_ctrl  = fetch_go ? ALU_ADD : ctrl_q.alu_ctrl;
   assign halted    = ctrl_q.halted;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Directed cycle-by-cycle check of mips_mc_ctrl. Two instances share all
// inputs: u_dut_h (HALT_ON_ILLEGAL=1) and u_dut_n (HALT_ON_ILLEGAL=0).
// Output words are packed as
// {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel,
//  alu_src_b, alu_ctrl, halted}.
// -----------------------------------------------------------------------------
module tb_mips_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       mem_req_h, mem_we_h, iord_h, ir_we_h, pc_we_h, reg_we_h, halted_h;
   logic [1:0] pc_src_h, reg_dst_h, wb_sel_h, alu_src_b_h;
   logic [2:0] alu_ctrl_h;
   logic       mem_req_n, mem_we_n, iord_n, ir_we_n, pc_we_n, reg_we_n, halted_n;
   logic [1:0] pc_src_n, reg_dst_n, wb_sel_n, alu_src_b_n;
   logic [2:0] alu_ctrl_n;

   logic [17:0] obs_h;
   logic [17:0] obs_n;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips_mc_ctrl #(.HALT_ON_ILLEGAL(1)) u_dut_h (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req_h), .mem_we(mem_we_h),
      .iord(iord_h), .ir_we(ir_we_h), .pc_we(pc_we_h), .pc_src(pc_src_h),
      .reg_we(reg_we_h), .reg_dst(reg_dst_h), .wb_sel(wb_sel_h),
      .alu_src_b(alu_src_b_h), .alu_ctrl(alu_ctrl_h), .halted(halted_h)
   );

   mips_mc_ctrl #(.HALT_ON_ILLEGAL(0)) u_dut_n (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req_n), .mem_we(mem_we_n),
      .iord(iord_n), .ir_we(ir_we_n), .pc_we(pc_we_n), .pc_src(pc_src_n),
      .reg_we(reg_we_n), .reg_dst(reg_dst_n), .wb_sel(wb_sel_n),
      .alu_src_b(alu_src_b_n), .alu_ctrl(alu_ctrl_n), .halted(halted_n)
   );

   assign obs_h = {mem_req_h, mem_we_h, iord_h, ir_we_h, pc_we_h, pc_src_h, reg_we_h,
                   reg_dst_h, wb_sel_h, alu_src_b_h, alu_ctrl_h, halted_h};
   assign obs_n = {mem_req_n, mem_we_n, iord_n, ir_we_n, pc_we_n, pc_src_n, reg_we_n,
                   reg_dst_n, wb_sel_n, alu_src_b_n, alu_ctrl_n, halted_n};

   task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] ev(input bit mreq, input bit mwe, input bit io,
                                      input bit irw, input bit pcw, input logic [1:0] pcs,
                                      input bit rw, input logic [1:0] rd, input logic [1:0] wb,
                                      input logic [1:0] bs, input logic [2:0] alu, input bit h);
      return {mreq, mwe, io, irw, pcw, pcs, rw, rd, wb, bs, alu, h};
   endfunction

   // Apply inputs for one cycle, check both instances mid-cycle, advance.
   task automatic cyc2(input string tag, input bit rst, input bit rdy, input bit z,
                       input logic [17:0] eh, input logic [17:0] en);
      rst_n     = rst;
      mem_ready = rdy;
      zero      = z;
      @(negedge clk);
      check({tag, "/h"}, obs_h, eh);
      check({tag, "/n"}, obs_n, en);
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input bit rdy, input bit z, input logic [17:0] e);
      cyc2(tag, 1'b1, rdy, z, e, e);
   endtask

   logic [17:0] E_IDLE, E_FW, E_FG, E_H, E_MA, E_MR, E_MW;
   logic [5:0]  fn_tab  [6];
   logic [2:0]  alu_tab [6];

   initial begin
      E_IDLE = '0;
      E_FW   = ev(1,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,3'b000,0);
      E_FG   = ev(1,0,0,1,1,2'd0,0,2'd0,2'd0,2'd1,3'b010,0);
      E_H    = ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,3'b000,1);
      E_MA   = ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd2,3'b010,0);
      E_MR   = ev(1,0,1,0,0,2'd0,0,2'd0,2'd0,2'd0,3'b000,0);
      E_MW   = ev(1,1,1,0,0,2'd0,0,2'd0,2'd0,2'd0,3'b000,0);
      fn_tab  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
      alu_tab = '{3'b110,    3'b000,    3'b001,    3'b111,    3'b100,    3'b101};

      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; funct = 6'd0;
      repeat (2) @(posedge clk);
      #1;

      // Out of reset: FETCH waiting on memory, only mem_req
      cyc("rst", 0, 0, E_FW);

      // ADD, mem_ready high throughout
      op = 6'b000000; funct = 6'b100000;
      cyc("add_f",  1, 0, E_FG);
      cyc("add_d",  1, 0, E_IDLE);
      cyc("add_x",  1, 0, ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,3'b010,0));
      cyc("add_wb", 1, 0, ev(0,0,0,0,0,2'd0,1,2'd1,2'd0,2'd0,3'b000,0));

      // Remaining R-type ALU ops: check the EXEC_R ALU code
      for (int i = 0; i < 6; i++) begin
         funct = fn_tab[i];
         cyc("r_f",  1, 0, E_FG);
         cyc("r_d",  1, 0, E_IDLE);
         cyc($sformatf("r_x%0d", i), 1, 0,
             ev(0,0,0,0,0,2'd0,0,2'd0,2'd0,2'd0,alu_tab[i],0));
         cyc("r_wb", 1, 0, ev(0,0,0,0,0,2'd0,1,2'd1,2'd0,2'd0,3'b000,0));
      end

      // ADDI: rt destination
      op = 6'b001000; funct = 6'd0;
      cyc("addi_f",  1, 0, E_FG);
      cyc("addi_d",  1, 0, E_IDLE);
      cyc("addi_x",  1, 0, E_MA);
      cyc("addi_wb", 1, 0, ev(0,0,0,0,0,2'd0,1,2'd0,2'd0,2'd0,3'b000,0));

      // LW with two stall cycles in MEM_RD
      op = 6'b100011;
      cyc("lw_f",   1, 0, E_FG);
      cyc("lw_d",   1, 0, E_IDLE);
      cyc("lw_ma",  1, 0, E_MA);
      cyc("lw_mr0", 0, 0, E_MR);
      cyc("lw_mr1", 0, 0, E_MR);
      cyc("lw_mr2", 1, 0, E_MR);
      cyc("lw_wb",  1, 0, ev(0,0,0,0,0,2'd0,1,2'd0,2'd1,2'd0,3'b000,0));
      cyc("lw_nxt", 0, 0, E_FW);

      // SW, no stall
      op = 6'b101011;
      cyc("sw_f",  1, 0, E_FG);
      cyc("sw_d",  1, 0, E_IDLE);
      cyc("sw_ma", 1, 0, E_MA);
      cyc("sw_mw", 1, 0, E_MW);

      // BEQ / BNE with both zero values
      op = 6'b000100;
      cyc("beq1_f", 1, 0, E_FG);
      cyc("beq1_d", 1, 0, E_IDLE);
      cyc("beq1_b", 1, 1, ev(0,0,0,0,1,2'd1,0,2'd0,2'd0,2'd0,3'b110,0));
      cyc("beq0_f", 1, 0, E_FG);
      cyc("beq0_d", 1, 0, E_IDLE);
      cyc("beq0_b", 1, 0, ev(0,0,0,0,0,2'd1,0,2'd0,2'd0,2'd0,3'b110,0));
      op = 6'b000101;
      cyc("bne0_f", 1, 0, E_FG);
      cyc("bne0_d", 1, 0, E_IDLE);
      cyc("bne0_b", 1, 0, ev(0,0,0,0,1,2'd1,0,2'd0,2'd0,2'd0,3'b110,0));
      cyc("bne1_f", 1, 0, E_FG);
      cyc("bne1_d", 1, 0, E_IDLE);
      cyc("bne1_b", 1, 1, ev(0,0,0,0,0,2'd1,0,2'd0,2'd0,2'd0,3'b110,0));

      // JAL and JR
      op = 6'b000011;
      cyc("jal_f", 1, 0, E_FG);
      cyc("jal_d", 1, 0, E_IDLE);
      cyc("jal_j", 1, 0, ev(0,0,0,0,1,2'd2,1,2'd2,2'd2,2'd0,3'b000,0));
      op = 6'b000000; funct = 6'b001000;
      cyc("jr_f", 1, 0, E_FG);
      cyc("jr_d", 1, 0, E_IDLE);
      cyc("jr_j", 1, 0, ev(0,0,0,0,1,2'd3,0,2'd0,2'd0,2'd0,3'b000,0));

      // Reset during a stalled SW
      op = 6'b101011; funct = 6'd0;
      cyc("swr_f",  1, 0, E_FG);
      cyc("swr_d",  1, 0, E_IDLE);
      cyc("swr_ma", 1, 0, E_MA);
      cyc("swr_mw", 0, 0, E_MW);
      cyc2("swr_rst", 1'b0, 0, 0, E_MW, E_MW);
      cyc("swr_aft", 0, 0, E_FW);

      // Illegal opcode: halt vs refetch
      op = 6'b111111; funct = 6'd0;
      cyc("ill_f", 1, 0, E_FG);
      cyc("ill_d", 1, 0, E_IDLE);
      cyc2("ill_3",   1'b1, 1, 0, E_H, E_FG);
      cyc2("ill_4",   1'b1, 1, 0, E_H, E_IDLE);
      cyc2("ill_rst", 1'b0, 0, 0, E_H, E_FW);
      cyc("ill_aft", 0, 0, E_FW);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
